// File: rtl/rv_alu_pkg.sv
// Shared opcode and state definitions for the EX-stage ALU.
package rv_alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1101;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_MUL1, S_DIV, S_FIX} state_t;

endpackage

// File: rtl/rv_alu_ex_div.sv
// Restoring radix-2 unsigned divider, one quotient bit per cycle.
module rv_div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_quot,
  output logic [XLEN-1:0] o_rem
);
  localparam int CW = $clog2(XLEN + 1);

  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_quot, r_rem, r_dvsr;
  logic            r_busy;
  logic [XLEN:0]   w_shift, w_trial;

  assign w_shift = {r_rem, r_quot[XLEN-1]};
  assign w_trial = w_shift - {1'b0, r_dvsr};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_quot <= '0;
      r_rem  <= '0;
      r_dvsr <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_quot <= i_dividend;
      r_rem  <= '0;
      r_dvsr <= i_divisor;
      r_cnt  <= CW'(XLEN);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      // borrow out of the trial subtraction means the divisor did not fit
      if (w_trial[XLEN]) begin
        r_rem  <= w_shift[XLEN-1:0];
        r_quot <= {r_quot[XLEN-2:0], 1'b0};
      end else begin
        r_rem  <= w_trial[XLEN-1:0];
        r_quot <= {r_quot[XLEN-2:0], 1'b1};
      end
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == CW'(1)) r_busy <= 1'b0;
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_busy && (r_cnt == CW'(1));
  assign o_quot = r_quot;
  assign o_rem  = r_rem;
endmodule

// File: rtl/rv_alu_ex.sv
// EX-stage RV32I/RV32M ALU with valid/ready handshakes on both sides.
// state  | meaning
// IDLE   | ready for an op; result register holds any pending result (DONE)
// MUL1   | 2*XLEN product registered, next edge selects the half
// DIV    | iterative divider running
// FIX    | sign fix / corner-case result written to the output
module rv_alu_ex
  import rv_alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int EN_M = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] rs1_in,
  input  logic [XLEN-1:0] rs2_in,
  input  logic [XLEN-1:0] imm_in,
  input  logic            use_imm,
  input  logic [2:0]      funct3,
  input  logic            funct7_r,
  input  logic            funct7_m,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rd_out,
  output logic            ovf_out,
  output logic            illegal_out
);
  localparam int SHW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  state_t            r_state;
  logic              r_out_valid, r_ovf, r_illegal, r_mul_hi, r_neg, r_is_rem, r_bypass;
  logic [XLEN-1:0]   r_rd, r_byp_val;
  logic [2*XLEN-1:0] r_prod;

  logic [XLEN-1:0]   w_op2, w_base, w_sum, w_diff, w_abs1, w_abs2, w_quot, w_rem, w_fix;
  logic [3:0]        w_op;
  logic [SHW-1:0]    w_sh;
  logic [2*XLEN-1:0] w_ma, w_mb, w_prod;
  logic              w_accept, w_illegal, w_ovf, w_is_mul, w_is_div, w_sgn, w_div0, w_dovf;
  logic              w_div_start, w_div_busy, w_div_done;

  assign in_ready = !rst && (r_state == S_IDLE) && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_op2    = use_imm ? imm_in : rs2_in;
  assign w_op     = {funct7_r, funct3};
  assign w_sh     = w_op2[SHW-1:0];
  assign w_sum    = rs1_in + w_op2;
  assign w_diff   = rs1_in - w_op2;

  assign w_illegal = (funct7_r && funct3 != 3'b000 && funct3 != 3'b101)
                  || (use_imm && funct7_r && funct3 == 3'b000)
                  || (use_imm && funct7_m)
                  || (funct7_m && (EN_M == 0))
                  || (funct7_m && funct7_r);
  assign w_is_mul = funct7_m && !funct3[2];
  assign w_is_div = funct7_m && funct3[2];

  always_comb begin
    w_base = '0;
    w_ovf  = 1'b0;
    case (w_op)
      OP_ADD: begin
        w_base = w_sum;
        w_ovf  = (rs1_in[XLEN-1] == w_op2[XLEN-1]) && (w_sum[XLEN-1] != rs1_in[XLEN-1]);
      end
      OP_SUB: begin
        w_base = w_diff;
        w_ovf  = (rs1_in[XLEN-1] != w_op2[XLEN-1]) && (w_diff[XLEN-1] != rs1_in[XLEN-1]);
      end
      OP_SLL:  w_base = rs1_in << w_sh;
      OP_SLT:  w_base = {{(XLEN-1){1'b0}}, $signed(rs1_in) < $signed(w_op2)};
      OP_SLTU: w_base = {{(XLEN-1){1'b0}}, rs1_in < w_op2};
      OP_XOR:  w_base = rs1_in ^ w_op2;
      OP_SRL:  w_base = rs1_in >> w_sh;
      OP_SRA:  w_base = $signed(rs1_in) >>> w_sh;
      OP_OR:   w_base = rs1_in | w_op2;
      OP_AND:  w_base = rs1_in & w_op2;
      default: ;
    endcase
  end

  // low 2*XLEN bits of the product of extended operands give the exact result
  assign w_ma   = {{XLEN{(funct3 != OP_MULHU) && rs1_in[XLEN-1]}}, rs1_in};
  assign w_mb   = {{XLEN{(funct3 == OP_MUL || funct3 == OP_MULH) && w_op2[XLEN-1]}}, w_op2};
  assign w_prod = w_ma * w_mb;

  assign w_sgn       = !funct3[0];
  assign w_abs1      = (w_sgn && rs1_in[XLEN-1]) ? -rs1_in : rs1_in;
  assign w_abs2      = (w_sgn && w_op2[XLEN-1]) ? -w_op2 : w_op2;
  assign w_div0      = (w_op2 == '0);
  assign w_dovf      = w_sgn && (rs1_in == MIN_VAL) && (w_op2 == '1);
  assign w_div_start = w_accept && !w_illegal && w_is_div && !w_div0 && !w_dovf;

  rv_div_iter #(.XLEN(XLEN)) u_div (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_div_start),
    .i_dividend (w_abs1),
    .i_divisor  (w_abs2),
    .o_busy     (w_div_busy),
    .o_done     (w_div_done),
    .o_quot     (w_quot),
    .o_rem      (w_rem)
  );

  assign w_fix = r_bypass ? r_byp_val
               : r_is_rem ? (r_neg ? -w_rem : w_rem)
               : (r_neg ? -w_quot : w_quot);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_rd        <= '0;
      r_ovf       <= 1'b0;
      r_illegal   <= 1'b0;
      r_mul_hi    <= 1'b0;
      r_neg       <= 1'b0;
      r_is_rem    <= 1'b0;
      r_bypass    <= 1'b0;
      r_byp_val   <= '0;
      r_prod      <= '0;
    end else begin
      if (r_out_valid && out_ready) r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: if (w_accept) begin
          if (w_illegal) begin
            r_rd        <= '0;
            r_ovf       <= 1'b0;
            r_illegal   <= 1'b1;
            r_out_valid <= 1'b1;
          end else if (w_is_mul) begin
            r_prod   <= w_prod;
            r_mul_hi <= (funct3 != OP_MUL);
            r_state  <= S_MUL1;
          end else if (w_is_div) begin
            r_is_rem  <= funct3[1];
            r_neg     <= w_sgn && (funct3[1] ? rs1_in[XLEN-1] : (rs1_in[XLEN-1] ^ w_op2[XLEN-1]));
            r_bypass  <= w_div0 || w_dovf;
            r_byp_val <= w_div0 ? (funct3[1] ? rs1_in : '1) : (funct3[1] ? '0 : MIN_VAL);
            r_state   <= (w_div0 || w_dovf) ? S_FIX : S_DIV;
          end else begin
            r_rd        <= w_base;
            r_ovf       <= w_ovf;
            r_illegal   <= 1'b0;
            r_out_valid <= 1'b1;
          end
        end
        S_MUL1: begin
          r_rd        <= r_mul_hi ? r_prod[2*XLEN-1:XLEN] : r_prod[XLEN-1:0];
          r_ovf       <= 1'b0;
          r_illegal   <= 1'b0;
          r_out_valid <= 1'b1;
          r_state     <= S_IDLE;
        end
        // the busy check only matters if the divider never started
        S_DIV: if (w_div_done || !w_div_busy) r_state <= S_FIX;
        S_FIX: begin
          r_rd        <= w_fix;
          r_ovf       <= 1'b0;
          r_illegal   <= 1'b0;
          r_out_valid <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_valid   = r_out_valid;
  assign rd_out      = r_rd;
  assign ovf_out     = r_ovf;
  assign illegal_out = r_illegal;
endmodule

// File: doc/rv_alu_ex.md
Name: rv_alu_ex

Overview:
Parametrised, handshaked successor to the combinational RV32I R-type ALU. Executes RV32I register and immediate ALU ops plus, optionally, the RV32M multiply/divide family. Single-cycle ops are registered. MUL* uses a 2-stage path; DIV*/REM* uses an iterative radix-2 divider. Sits in the EX stage between decode (valid/ready producer) and writeback (valid/ready consumer), and adds signed-overflow reporting.

Parameters:
XLEN, 32, datapath width (≥8, power of 2)
EN_M, 1, 1 = RV32M ops legal; 0 = funct7_m ops flagged illegal
SHW, $clog2(XLEN), shift-amount width (derived, not overridden)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
in_valid  in  1  operation presented
in_ready  out  1  block accepts operation this cycle
rs1_in  in  XLEN  operand 1
rs2_in  in  XLEN  operand 2 (register form)
imm_in  in  XLEN  sign-extended immediate (I-type form)
use_imm  in  1  1 = operand 2 is imm_in
funct3  in  3  RISC-V funct3
funct7_r  in  1  funct7[5] (SUB/SRA/SRAI)
funct7_m  in  1  funct7[0] (M-extension select)
out_valid  out  1  result available
out_ready  in  1  consumer takes result
rd_out  out  XLEN  result
ovf_out  out  1  signed overflow (ADD/ADDI/SUB only)
illegal_out  out  1  encoding illegal; rd_out = 0

Behaviour:
- Reset (async, rst=1): state IDLE; out_valid=0, rd_out=0, ovf_out=0, illegal_out=0, divider cleared. in_ready=0 while rst=1.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Accept when in_valid && in_ready. Operands are captured at accept; inputs are don't-care afterwards.
- op2 = use_imm ? imm_in : rs2_in. Shifts use op2[SHW-1:0].
- Base ops ({funct7_r,funct3}): ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND. Same semantics as RV32I, at XLEN width.
- Illegal, flagged with latency 1:
  - funct7_r=1 with funct3 ∉ {000,101}
  - use_imm && funct7_r && funct3=000 (no SUBI)
  - use_imm && funct7_m
  - funct7_m && EN_M=0
  - funct7_m && funct7_r
- Latency (accept edge to out_valid=1):
  - Base/illegal: 1 cycle.
  - MUL/MULH/MULHSU/MULHU: 2 cycles. Stage 1 registers the 2·XLEN product (operands sign/zero-extended per op); stage 2 selects the low or high half.
  - DIV/DIVU/REM/REMU: XLEN+2 cycles. Signed ops run on magnitudes with a final sign fix.
- ovf_out:
  - ADD: (a[msb]==b[msb]) && (sum[msb]!=a[msb]).
  - SUB: (a[msb]!=b[msb]) && (diff[msb]!=a[msb]).
  - 0 for all other ops.
- Division corner cases, exact RISC-V values:
  - Divide by zero: quotient = all-ones, remainder = rs1. Completes in 2 cycles, skipping iteration.
  - Signed overflow (MIN / -1): quotient = MIN, remainder = 0, 2 cycles.
- FSM:
  - IDLE → BASE (base/illegal) | MUL1 | DIV (on accept).
  - BASE → DONE.
  - MUL1 → MUL2 → DONE.
  - DIV counts XLEN iterations → FIX → DONE.
  - DONE: out_valid=1; hold rd_out/ovf_out/illegal_out stable until out_ready. On out_ready, go to IDLE, or directly into the next op if in_valid is accepted the same cycle.
- Back-to-back: with out_ready held at 1, base ops sustain one result per cycle (DONE and accept overlap).
- Reset mid-operation discards any in-flight divide/multiply. No result is emitted.

Decomposition:
- Package rv_alu_pkg: {funct7_r,funct3} base opcode localparams (OP_ADD…OP_AND); M-ext funct3 localparams (OP_MUL…OP_REMU); FSM state encoding.
- One sub-module, rv_div_iter: restoring radix-2 unsigned divider with start/busy/done, XLEN-parameterised, outputs quotient and remainder. Sign handling and corner cases stay in rv_alu_ex.

Test Plan:
- ADD rs1=0x7FFFFFFF, rs2=1, out_ready=1 → 1 cycle later rd=0x80000000, ovf=1. SUB 0x80000000−1 → rd=0x7FFFFFFF, ovf=1.
- SRAI use_imm=1, funct7_r=1, rs1=0x80000000, imm=4 → rd=0xF8000000. use_imm=1, funct7_r=1, funct3=000 → illegal=1, rd=0.
- MULH rs1=0xFFFFFFFF (-1), rs2=2 → out_valid after 2 cycles, rd=0xFFFFFFFF. MULHU same operands → rd=0x00000001.
- DIV 7/-2 → rd=0xFFFFFFFD after 34 cycles; REM → rd=1. DIVU x/0 → 0xFFFFFFFF; REM x/0 → x. DIV 0x80000000/-1 → 0x80000000; REM → 0.
- Backpressure: out_ready=0 for 5 cycles after a result → rd_out stable, in_ready=0. Raise out_ready with in_valid=1 → next op accepted that same cycle.
- Assert rst at cycle 10 of a DIV → out_valid=0 immediately. After release, in_ready=1 and a new ADD completes with the correct result.
